scan_crypto_sequencer: RTL and testbench

SCAN_CRYPTO_SEQUENCER -- requirements
Module: scan_crypto_sequencer

---
 rtl/scan_crypto_pkg.sv | 17 +
 rtl/scan_crypto_sequencer_wdog.sv | 28 ++
 rtl/scan_crypto_sequencer.sv | 159 +++++++++++++++
 tb/tb_scan_crypto_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_crypto_pkg.sv
// Shared types and defaults for the secure-scan crypto sequencer.
package scan_crypto_pkg;

    localparam int unsigned BLK_W_DEF = 128;
    localparam int unsigned TMO_W_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY_RST,
        ST_KEY_EXP,
        ST_READY,
        ST_SHIFT,
        ST_BLK_WAIT,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/scan_crypto_sequencer_wdog.sv
// Watchdog for the secure-scan sequencer; cleared whenever i_run is low.
module scan_crypto_wdog
    import scan_crypto_pkg::*;
#(
    parameter int unsigned TMO_W = TMO_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_expire
);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_run) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires on the cycle the count steps to all-ones, so the owner leaves exactly 2**TMO_W-1 cycles after entry.
    assign o_expire = i_run && (r_cnt == {{(TMO_W-1){1'b1}}, 1'b0});

endmodule

// File: rtl/scan_crypto_sequencer.sv
// Secure-scan crypto sequencer: key expansion handshake, block shift counting, error tracking.
// Define SCAN_CRYPTO_TIMEOUT_EN to add a watchdog on KEY_EXP and BLK_WAIT.
module scan_crypto_sequencer
    import scan_crypto_pkg::*;
#(
    parameter int unsigned BLK_W = BLK_W_DEF,
    parameter int unsigned TMO_W = TMO_W_DEF
) (
    input  logic                     tck,
    input  logic                     trst_n,
    input  logic                     sel,
    input  logic                     capture_en,
    input  logic                     shift_en,
    input  logic                     update_en,
    input  logic                     ka_done,
    input  logic                     blk_done,
    output logic                     ka_rst_n,
    output logic                     ka_start,
    output logic                     crypt_en,
    output logic                     blk_start,
    output logic [$clog2(BLK_W)-1:0] bit_cnt,
    output logic                     ready,
    output logic                     err
);

    localparam int unsigned        CNT_W    = $clog2(BLK_W);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(BLK_W - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_ka_rst_n;
    logic             r_ka_start;
    logic             r_crypt_en;
    logic             r_blk_start;
    logic             r_ready;
    logic             r_err;
    logic             w_wd_expire;

`ifdef SCAN_CRYPTO_TIMEOUT_EN
    logic w_wd_run;

    assign w_wd_run = (r_state == ST_KEY_EXP) || (r_state == ST_BLK_WAIT);

    scan_crypto_wdog #(
        .TMO_W (TMO_W)
    ) u_wdog (
        .i_clk    (tck),
        .i_rst_n  (trst_n),
        .i_run    (w_wd_run),
        .o_expire (w_wd_expire)
    );
`else
    // No watchdog: never expires (TMO_W is always at least 1).
    assign w_wd_expire = (TMO_W == 0);
`endif

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_ka_rst_n  <= 1'b0;
            r_ka_start  <= 1'b0;
            r_crypt_en  <= 1'b0;
            r_blk_start <= 1'b0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ka_start  <= 1'b0;
            r_blk_start <= 1'b0;
            r_ka_rst_n  <= 1'b1;
            if (!sel) begin
                r_state    <= ST_IDLE;
                r_bit_cnt  <= '0;
                r_ready    <= 1'b0;
                r_crypt_en <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state    <= ST_KEY_RST;
                        r_ka_rst_n <= 1'b0;
                        r_err      <= 1'b0;
                    end
                    ST_KEY_RST: begin
                        r_state    <= ST_KEY_EXP;
                        r_ka_start <= 1'b1;
                    end
                    ST_KEY_EXP: begin
                        if (ka_done) begin
                            r_state <= ST_READY;
                            r_ready <= 1'b1;
                        end else if (w_wd_expire) begin
                            r_state    <= ST_ERROR;
                            r_err      <= 1'b1;
                            r_crypt_en <= 1'b0;
                            r_ready    <= 1'b0;
                        end
                    end
                    // READY and SHIFT share the bit-counting path; the first shifted bit leaves READY.
                    ST_READY, ST_SHIFT: begin
                        if (shift_en) begin
                            r_crypt_en <= 1'b1;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_bit_cnt   <= '0;
                                r_blk_start <= 1'b1;
                                r_state     <= ST_BLK_WAIT;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                r_state   <= ST_SHIFT;
                            end
                        end else if (r_state == ST_READY) begin
                            if (capture_en) begin
                                r_bit_cnt <= '0;
                            end
                        end else if (update_en) begin
                            if (r_bit_cnt != '0) begin
                                r_state    <= ST_ERROR;
                                r_err      <= 1'b1;
                                r_crypt_en <= 1'b0;
                                r_ready    <= 1'b0;
                            end else begin
                                r_state    <= ST_READY;
                                r_crypt_en <= 1'b0;
                            end
                        end
                    end
                    ST_BLK_WAIT: begin
                        if (blk_done) begin
                            r_state <= ST_SHIFT;
                            if (shift_en) begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else if (shift_en || w_wd_expire) begin
                            r_state    <= ST_ERROR;
                            r_err      <= 1'b1;
                            r_crypt_en <= 1'b0;
                            r_ready    <= 1'b0;
                        end
                    end
                    ST_ERROR: begin
                        r_crypt_en <= 1'b0;
                        r_ready    <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ka_rst_n  = r_ka_rst_n;
    assign ka_start  = r_ka_start;
    assign crypt_en  = r_crypt_en;
    assign blk_start = r_blk_start;
    assign bit_cnt   = r_bit_cnt;
    assign ready     = r_ready;
    assign err       = r_err;

endmodule

// File: tb/tb_scan_crypto_sequencer.sv
// Scoreboard bench for scan_crypto_sequencer: directed stimulus queues expectations, a monitor compares at negedge.
module tb_scan_crypto_sequencer;

    localparam int unsigned BLK = 128;

    localparam int S_KARST = 0;
    localparam int S_KAST  = 1;
    localparam int S_CE    = 2;
    localparam int S_BLKS  = 3;
    localparam int S_CNT   = 4;
    localparam int S_RDY   = 5;
    localparam int S_ERR   = 6;

    logic       tck = 1'b0;
    logic       trst_n = 1'b0;
    logic       sel = 1'b0;
    logic       capture_en = 1'b0;
    logic       shift_en = 1'b0;
    logic       update_en = 1'b0;
    logic       ka_done = 1'b0;
    logic       blk_done = 1'b0;
    logic       ka_rst_n;
    logic       ka_start;
    logic       crypt_en;
    logic       blk_start;
    logic [6:0] bit_cnt;
    logic       ready;
    logic       err;

    scan_crypto_sequencer #(
        .BLK_W (BLK),
        .TMO_W (6)
    ) dut (
        .tck        (tck),
        .trst_n     (trst_n),
        .sel        (sel),
        .capture_en (capture_en),
        .shift_en   (shift_en),
        .update_en  (update_en),
        .ka_done    (ka_done),
        .blk_done   (blk_done),
        .ka_rst_n   (ka_rst_n),
        .ka_start   (ka_start),
        .crypt_en   (crypt_en),
        .blk_start  (blk_start),
        .bit_cnt    (bit_cnt),
        .ready      (ready),
        .err        (err)
    );

    always #5 tck = ~tck;

    int cyc = 0;
    always @(posedge tck) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    typedef struct {
        int cyc;
        int sig;
    } pulse_t;

    exp_t   exp_q[$];
    pulse_t pulse_q[$];
    int     n_checks = 0;
    int     n_err = 0;

    function automatic int get_sig(int s);
        case (s)
            S_KARST: return int'(ka_rst_n);
            S_KAST:  return int'(ka_start);
            S_CE:    return int'(crypt_en);
            S_BLKS:  return int'(blk_start);
            S_CNT:   return int'(bit_cnt);
            S_RDY:   return int'(ready);
            default: return int'(err);
        endcase
    endfunction

    task automatic chk(input string n, input int s, input int v);
        exp_t e;
        e.cyc = cyc; e.sig = s; e.val = v; e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic chk_pulse(input int s);
        pulse_t p;
        p.cyc = cyc; p.sig = s;
        pulse_q.push_back(p);
    endtask

    // Monitor: pulse outputs are matched against the pulse queue, level outputs against the cycle-tagged queue.
    always @(negedge tck) begin
        exp_t   e;
        pulse_t p;
        while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
            p = pulse_q.pop_front();
            n_checks++; n_err++;
            $display("FAIL missed_pulse sig%0d: got none, expected at cyc %0d", p.sig, p.cyc);
        end
        if (ka_start && blk_start) begin
            n_checks++; n_err++;
            $display("FAIL pulse_overlap @cyc %0d: got ka_start=1 blk_start=1, expected not both", cyc);
        end
        for (int s = S_KAST; s <= S_BLKS; s += 2) begin
            if (get_sig(s) == 1) begin
                n_checks++;
                if (pulse_q.size() == 0 || pulse_q[0].cyc != cyc || pulse_q[0].sig != s) begin
                    n_err++;
                    $display("FAIL unexpected_pulse sig%0d @cyc %0d: got 1, expected 0", s, cyc);
                end else begin
                    p = pulse_q.pop_front();
                end
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                n_err++;
                $display("FAIL %s: not sampled at cyc %0d, expected %0d", e.name, e.cyc, e.val);
            end else if (get_sig(e.sig) != e.val) begin
                n_err++;
                $display("FAIL %s @cyc %0d: got %0d, expected %0d", e.name, cyc, get_sig(e.sig), e.val);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge tck);
            #1;
        end
    endtask

    task automatic chk_reset_vals(input string n);
        chk({n, "_karst"}, S_KARST, 0);
        chk({n, "_kast"},  S_KAST,  0);
        chk({n, "_ce"},    S_CE,    0);
        chk({n, "_blks"},  S_BLKS,  0);
        chk({n, "_cnt"},   S_CNT,   0);
        chk({n, "_rdy"},   S_RDY,   0);
        chk({n, "_err"},   S_ERR,   0);
    endtask

    task automatic bring_up(input int wait_n);
        sel = 1'b1;
        tick();
        chk("keyrst_low", S_KARST, 0);
        chk("err_cleared", S_ERR, 0);
        tick();
        chk("keyrst_high", S_KARST, 1);
        chk_pulse(S_KAST);
        repeat (wait_n) begin
            tick();
            chk("not_ready_yet", S_RDY, 0);
        end
        ka_done = 1'b1;
        tick();
        chk("ready_up", S_RDY, 1);
        chk("ready_ce_off", S_CE, 0);
        ka_done = 1'b0;
    endtask

    task automatic shift_bits(input int n, input int c0);
        int c;
        shift_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            c = (c0 + i + 1) % BLK;
            chk("shift_cnt", S_CNT, c);
            chk("shift_ce", S_CE, 1);
            if (c == 0) chk_pulse(S_BLKS);
        end
    endtask

    initial begin
        // Reset values while trst_n is held low
        tick();
        chk_reset_vals("rst");
        tick();
        trst_n = 1'b1;
        tick();
        chk("idle_karst", S_KARST, 1);
        tick();

        // Key bring-up with ka_done arriving 10 cycles after sel
        bring_up(7);

        // Full block, blk_done three cycles after the last bit, then update
        shift_bits(BLK, 0);
        shift_en = 1'b0;
        tick();
        chk("bw_ce", S_CE, 1);
        chk("bw_rdy", S_RDY, 1);
        tick();
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        chk("after_done_ce", S_CE, 1);
        update_en = 1'b1;
        tick();
        update_en = 1'b0;
        chk("upd_rdy", S_RDY, 1);
        chk("upd_ce", S_CE, 0);
        chk("upd_cnt", S_CNT, 0);
        chk("upd_err", S_ERR, 0);

        // Overrun: shift_en held through BLK_WAIT without blk_done
        shift_bits(BLK, 0);
        tick();
        shift_en = 1'b0;
        chk("ovr_err", S_ERR, 1);
        chk("ovr_ce", S_CE, 0);
        chk("ovr_rdy", S_RDY, 0);
        sel = 1'b0;
        tick();
        chk("seloff_err_kept", S_ERR, 1);
        chk("seloff_cnt", S_CNT, 0);
        bring_up(0);

        // Partial block at update
        shift_bits(50, 0);
        shift_en = 1'b0;
        update_en = 1'b1;
        tick();
        update_en = 1'b0;
        chk("partial_err", S_ERR, 1);
        chk("partial_ce", S_CE, 0);
        chk("partial_rdy", S_RDY, 0);
        sel = 1'b0;
        tick();
        chk("partial_err_kept", S_ERR, 1);
        bring_up(2);

        // blk_done and shift_en together in BLK_WAIT, then reset at bit 70
        shift_bits(BLK, 0);
        shift_en = 1'b0;
        tick();
        chk("bw2_ce", S_CE, 1);
        shift_en = 1'b1;
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        chk("same_cyc_cnt", S_CNT, 1);
        chk("same_cyc_err", S_ERR, 0);
        chk("same_cyc_ce", S_CE, 1);
        shift_bits(69, 1);
        shift_en = 1'b0;
        tick();
        #1;
        trst_n = 1'b0;
        sel = 1'b0;
        chk_reset_vals("async_rst");
        tick();
        trst_n = 1'b1;
        tick();
        chk("post_rst_karst", S_KARST, 1);
        chk("post_rst_cnt", S_CNT, 0);
        bring_up(0);

        // sel drop mid-shift
        shift_bits(5, 0);
        shift_en = 1'b0;
        sel = 1'b0;
        tick();
        chk("seldrop_cnt", S_CNT, 0);
        chk("seldrop_ce", S_CE, 0);
        chk("seldrop_rdy", S_RDY, 0);
        chk("seldrop_err", S_ERR, 0);

        // KEY_EXP with ka_done withheld
        sel = 1'b1;
        tick();
        chk("kx_keyrst", S_KARST, 0);
        tick();
        chk_pulse(S_KAST);
`ifdef SCAN_CRYPTO_TIMEOUT_EN
        tick(62);
        chk("wd_not_yet", S_ERR, 0);
        tick();
        chk("wd_err", S_ERR, 1);
        chk("wd_rdy", S_RDY, 0);
`else
        tick(1000);
        chk("nowd_err", S_ERR, 0);
        chk("nowd_rdy", S_RDY, 0);
        ka_done = 1'b1;
        tick();
        ka_done = 1'b0;
        chk("nowd_late_ready", S_RDY, 1);
`endif
        sel = 1'b0;
        tick(4);

        foreach (exp_q[i]) begin
            n_checks++; n_err++;
            $display("FAIL %s: never sampled, expected %0d", exp_q[i].name, exp_q[i].val);
        end
        foreach (pulse_q[i]) begin
            n_checks++; n_err++;
            $display("FAIL pending_pulse sig%0d: got none, expected at cyc %0d", pulse_q[i].sig, pulse_q[i].cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
